multi_click: RTL
================

Name: multi_click

Overview:
- Parametrised multi-channel button gesture detector. Successor to the single-channel single/double click detector.
- Per channel: synchronises and debounces a raw button and counts clicks within a burst.
- Reports the burst as a one-cycle pulse with a click count, or as a long-press event.
- Sits between board push-buttons and the controller/test-mode logic that selects SDRAM test patterns.

Parameters:
- CHANNELS, 2: number of independent button channels.
- WAIT_WIDTH, 4: width of the per-channel gap/hold timer. TMAX = 2^WAIT_WIDTH-1 cycles.
- DEBOUNCE_CYCLES, 2: consecutive stable synchronised cycles required to change the debounced level. 0 = bypass.
- CNT_WIDTH, 2: click counter width. Counter saturates at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- button  input  CHANNELS  raw asynchronous button levels, 1 = pressed.
- click_valid  output  CHANNELS  one-cycle pulse: burst of short clicks completed.
- long_press  output  CHANNELS  one-cycle pulse: current press held TMAX cycles.
- click_count  output  CHANNELS*CNT_WIDTH  channel i at [i*CNT_WIDTH +: CNT_WIDTH]. Holds the last reported count.
- busy  output  CHANNELS  1 while the channel FSM is not IDLE.

Behaviour:
- Reset is one clock with asynchronous, active-high reset (rst). While rst = 1, every flop clears: sync, debounce, FSM = IDLE, timers, counters. All outputs are 0.
- Reset asserted mid-burst discards the burst. No pulse is emitted after reset releases.
- Channels are fully independent. No shared state. Simultaneous events on different channels are each reported in the same cycle.
- Synchroniser: 2 flops per channel, giving s.
- Debounce: level d is stored. A counter increments while s != d and clears when s == d. When the counter reaches DEBOUNCE_CYCLES, d <= s and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles at s never reach d.
  - Raw edge to d edge latency = 2 + DEBOUNCE_CYCLES cycles.
- FSM per channel, states IDLE, PRESS, HOLD, GAP. Single timer t[WAIT_WIDTH-1:0] and counter n[CNT_WIDTH-1:0].
  - IDLE: d=1 -> PRESS, t=0, n=0.
  - PRESS: d=0 -> GAP, n = sat(n+1), t=0. Else if t==TMAX -> HOLD, long_press=1 for one cycle, click_count <= n (completed clicks before the hold). Else t++.
  - HOLD: t frozen. d=0 -> IDLE. No click_valid for this burst.
  - GAP: d=1 -> PRESS, t=0. Else if t==TMAX -> IDLE, click_valid=1 for one cycle, click_count <= n. Else t++.
  - If a release/press edge and t==TMAX occur in the same cycle, the edge wins.
- sat(n+1): n stays at 2^CNT_WIDTH-1 once reached. No wrap.
- click_count updates only in the cycle its pulse is asserted, then holds.
- click_valid and long_press are never both 1 on one channel.
- busy = (state != IDLE), registered with the state.
- Report latency: click_valid asserts TMAX+1 cycles after d falls on the last click.
- Long-press timing: long_press asserts TMAX+1 cycles after d rises.

Test Plan (CHANNELS=2, WAIT_WIDTH=4 so TMAX=15, DEBOUNCE_CYCLES=2, CNT_WIDTH=2):
- Reset, then ch0 pressed 6 cycles -> exactly one click_valid[0] pulse 16 cycles after ch0 d falls, click_count[1:0]=1. ch1 outputs stay 0.
- ch0: 6 on, 5 off, 6 on -> one click_valid[0], click_count=2. No pulse between the clicks.
- ch0 held 40 cycles -> long_press[0] pulse 16 cycles after d rises, click_count=0. No click_valid[0] after release. busy[0] drops 1 cycle after d falls.
- 1-cycle raw glitch on ch1 -> d never changes, busy[1] stays 0, no pulses.
- 5 quick clicks (6 on/5 off) on ch0 -> click_count saturates at 3, single click_valid[0].
- Simultaneous single click on both channels -> click_valid=2'b11 in the same cycle, both counts 1.
- rst asserted during ch0 GAP -> all outputs 0 immediately. No click_valid after rst releases.

Source files
------------

// File: rtl/multi_click.sv
`default_nettype none
// ============================================================================
// Module      : multi_click
// Description : Multi-channel push-button gesture detector. Each channel
//               synchronises and debounces a raw button, counts the clicks
//               of a burst and reports either a completed burst
//               (click_valid + click_count) or a long press (long_press).
//               Channels share no state.
//
// Ports       : clk          system clock, all logic on the rising edge
//               rst          asynchronous active-high reset
//               button       [CHANNELS] raw button levels, 1 = pressed
//               click_valid  [CHANNELS] one-cycle pulse, burst completed
//               long_press   [CHANNELS] one-cycle pulse, press held TMAX cycles
//               click_count  [CHANNELS*CNT_WIDTH] last reported count,
//                            channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//               busy         [CHANNELS] channel gesture FSM not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module multi_click #(
    parameter int CHANNELS        = 2,
    parameter int WAIT_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_WIDTH       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           button,
    output logic [CHANNELS-1:0]           click_valid,
    output logic [CHANNELS-1:0]           long_press,
    output logic [CHANNELS*CNT_WIDTH-1:0] click_count,
    output logic [CHANNELS-1:0]           busy
);

    // Timer terminal value (TMAX) and click counter saturation value.
    localparam logic [WAIT_WIDTH-1:0] c_tmax = '1;
    localparam logic [CNT_WIDTH-1:0]  c_nmax = '1;

    // Gesture FSM encoding.
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_press = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan

            // ------------------------------------------------------------
            // Two-flop synchroniser
            // ------------------------------------------------------------
            logic r_sync1;
            logic r_sync2;
            logic w_deb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= button[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // ------------------------------------------------------------
            // Debounce: the stored level follows the synchronised level
            // only after it has differed for DEBOUNCE_CYCLES consecutive
            // cycles. Any agreeing cycle restarts the count.
            // ------------------------------------------------------------
            if (DEBOUNCE_CYCLES == 0) begin : g_bypass
                assign w_deb = r_sync2;
            end else begin : g_debounce
                localparam int c_dw = $clog2(DEBOUNCE_CYCLES + 1);
                localparam logic [c_dw-1:0] c_last = c_dw'(DEBOUNCE_CYCLES - 1);

                logic [c_dw-1:0] r_cnt;
                logic            r_level;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_last) begin
                        // This cycle is the DEBOUNCE_CYCLES-th differing one.
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                assign w_deb = r_level;
            end

            // ------------------------------------------------------------
            // Gesture FSM: one shared timer for press length and gap length
            // ------------------------------------------------------------
            logic [1:0]            r_state;
            logic [1:0]            w_state_nxt;
            logic [WAIT_WIDTH-1:0] r_t;
            logic [WAIT_WIDTH-1:0] w_t_nxt;
            logic [CNT_WIDTH-1:0]  r_n;
            logic [CNT_WIDTH-1:0]  w_n_nxt;
            logic [CNT_WIDTH-1:0]  r_last;
            logic                  w_click;
            logic                  w_long;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= c_st_idle;
                    r_t     <= '0;
                    r_n     <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_t     <= w_t_nxt;
                    r_n     <= w_n_nxt;
                end
            end

            // Pulses are decoded from the transition itself so that they
            // appear in the same cycle the timer expires; a level edge seen
            // in that cycle takes priority over the expiry.
            always_comb begin
                w_state_nxt = r_state;
                w_t_nxt     = r_t;
                w_n_nxt     = r_n;
                w_click     = 1'b0;
                w_long      = 1'b0;
                case (r_state)
                    c_st_idle: begin
                        if (w_deb) begin
                            w_state_nxt = c_st_press;
                            w_t_nxt     = '0;
                            w_n_nxt     = '0;
                        end
                    end
                    c_st_press: begin
                        if (!w_deb) begin
                            w_state_nxt = c_st_gap;
                            w_t_nxt     = '0;
                            w_n_nxt     = (r_n == c_nmax) ? r_n : r_n + 1'b1;
                        end else if (r_t == c_tmax) begin
                            w_state_nxt = c_st_hold;
                            w_long      = 1'b1;
                        end else begin
                            w_t_nxt = r_t + 1'b1;
                        end
                    end
                    c_st_hold: begin
                        // Timer frozen; wait for release, burst is dropped.
                        if (!w_deb) begin
                            w_state_nxt = c_st_idle;
                        end
                    end
                    c_st_gap: begin
                        if (w_deb) begin
                            w_state_nxt = c_st_press;
                            w_t_nxt     = '0;
                        end else if (r_t == c_tmax) begin
                            w_state_nxt = c_st_idle;
                            w_click     = 1'b1;
                        end else begin
                            w_t_nxt = r_t + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                    end
                endcase
            end

            // Reported count: shows the live count during the pulse cycle
            // and holds it afterwards.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_last <= '0;
                end else if (w_click || w_long) begin
                    r_last <= r_n;
                end
            end

            assign click_valid[gi] = w_click;
            assign long_press[gi]  = w_long;
            assign busy[gi]        = (r_state != c_st_idle);
            assign click_count[gi*CNT_WIDTH +: CNT_WIDTH] =
                (w_click || w_long) ? r_n : r_last;
        end
    endgenerate

endmodule
`default_nettype wire
